multi_clock_divider: RTL and testbench
======================================

Name: multi_clock_divider

Overview:
Parametrised, multi-channel successor to the fixed single-output clock divider. Generates NUM_CH independent square-wave enables (50% duty) from clk, each with its own runtime-programmable half-period, a per-channel run enable, and a one-cycle rising-edge tick. Divisor writes take effect glitch-free at the next full-period boundary. Outputs drive logic in the clk domain (tick-style enables), not global clock nets.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 32, width of half-period divisor and per-channel counter
CLK_FREQ, 50_000_000, input clock frequency in Hz
DEF_FREQ, 2, reset output frequency in Hz for every channel; reset half-period DEF_HALF = CLK_FREQ/(2*DEF_FREQ)
CH_W, max(1,clog2(NUM_CH)), width of channel select

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  NUM_CH  per-channel run enable, level-sensitive
wr_en  in  1  one-cycle divisor write strobe
wr_ch  in  CH_W  target channel of write
wr_half  in  CNT_W  new half-period in clk cycles
clk_div  out  NUM_CH  divided square wave per channel
tick  out  NUM_CH  one-cycle pulse on each 0->1 transition of clk_div
pending  out  NUM_CH  written divisor not yet applied

Behaviour:
- Reset (async, any time incl. mid-period): count=0, clk_div=0, tick=0, pending=0, active_half=pending_half=DEF_HALF for all channels.
- Effective half-period H = max(active_half,1); wr_half=0 behaves as 1 (toggle every cycle).
- Channel enabled: count increments each clk; when count==H-1, count<=0 and clk_div toggles. Full period 2*H cycles, exactly H high / H low.
- tick[i]=1 for exactly the cycle after clk_div[i] goes 0->1 (registered, aligned with clk_div high first cycle); never on 1->0.
- First toggle after en rises (or reset release) occurs H cycles later: clk_div goes high at cycle H, tick same cycle.
- en low: count held at 0, clk_div forced 0 next edge, tick 0. No tick generated by the forced 1->0. Re-enable restarts from count 0.
- Write: wr_en with wr_ch<NUM_CH loads pending_half[wr_ch], sets pending[wr_ch] next cycle. wr_ch>=NUM_CH ignored, no state change.
- Apply point: enabled channel at count==H-1 with clk_div==1 (end of high phase = end of full period). Then active_half<=pending_half, pending<=0; new H governs the very next low phase. Disabled channel: applied on the next clk edge after write.
- Write in same cycle as apply point on same channel: wr_half applied directly (bypass), pending stays 0.
- Back-to-back writes before apply: last written value wins; only one apply.
- Channels fully independent; writes to one never disturb another's count or phase.
- Counter arithmetic unsigned CNT_W bits; H never exceeds 2^CNT_W-1, so no wrap occurs.

Test Plan:
- NUM_CH=2, CLK_FREQ=12, DEF_FREQ=2 (DEF_HALF=3), en=2'b11 after reset -> both clk_div high cycles 3-5, low 6-8, period 6; tick single pulse at cycles 3, 9, 15.
- Write ch0 wr_half=5 at cycle 4 -> pending[0]=1 from cycle 5; ch0 keeps H=3 until end of high phase (cycle 5), then low 5 cycles, high 5; pending clears; ch1 unchanged.
- Write wr_half=0 to ch1 -> after apply ch1 toggles every cycle, tick every 2 cycles.
- Drop en[0] mid-high-phase -> clk_div[0]=0 next cycle, no tick; raise en[0] -> first rising edge exactly H cycles later.
- Write to wr_ch=3 with NUM_CH=2 -> no output or pending change on any channel.
- Assert rst mid-period with pending write -> outputs 0 immediately; after release all channels run at DEF_HALF, pending=0.

Source files
------------

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable square-wave divider with per-channel run enable,
// rising-edge tick, and divisor updates deferred to the next full-period boundary.

module mcd_channel #(
  parameter int CNT_W    = 32,
  parameter int DEF_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_half,
  output logic             clk_div,
  output logic             tick,
  output logic             pending
);
  logic [CNT_W-1:0] count, active_half, pending_half, h_eff;
  logic             at_end, apply_pt;

  assign h_eff  = (active_half == '0) ? CNT_W'(1) : active_half;
  assign at_end = (count == h_eff - CNT_W'(1));
  // Running channels swap only at end of the high phase; idle channels swap at once.
  assign apply_pt = en ? (at_end && clk_div) : pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      clk_div      <= 1'b0;
      tick         <= 1'b0;
      pending      <= 1'b0;
      active_half  <= CNT_W'(DEF_HALF);
      pending_half <= CNT_W'(DEF_HALF);
    end else begin
      if (en) begin
        if (at_end) begin
          count   <= '0;
          clk_div <= ~clk_div;
          tick    <= ~clk_div;
        end else begin
          count <= count + CNT_W'(1);
          tick  <= 1'b0;
        end
      end else begin
        count   <= '0;
        clk_div <= 1'b0;
        tick    <= 1'b0;
      end

      if (wr_hit && apply_pt) begin
        active_half  <= wr_half;
        pending_half <= wr_half;
        pending      <= 1'b0;
      end else if (wr_hit) begin
        pending_half <= wr_half;
        pending      <= 1'b1;
      end else if (apply_pt && pending) begin
        active_half <= pending_half;
        pending     <= 1'b0;
      end
    end
  end
endmodule

module multi_clock_divider #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int CLK_FREQ = 50_000_000,
  parameter int DEF_FREQ = 2,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_half,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);
  localparam int DEF_HALF = CLK_FREQ / (2 * DEF_FREQ);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_hit;
    // Out-of-range channel numbers never match, so such writes are dropped.
    assign wr_hit = wr_en && (wr_ch == CH_W'(i));

    mcd_channel #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .wr_hit  (wr_hit),
      .wr_half (wr_half),
      .clk_div (clk_div[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider: a down-counting phase model predicts
// clk_div/tick/pending each cycle, plus directed checks on tick timing.

module tb_multi_clock_divider;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;
  localparam int DEF_H  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_half;
  logic [NUM_CH-1:0] clk_div, tick, pending;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [5:0] sb[$];

  int m_rem[NUM_CH];
  int m_act[NUM_CH];
  int m_pv[NUM_CH];
  bit m_lvl[NUM_CH];
  bit m_tick[NUM_CH];
  bit m_pend[NUM_CH];

  multi_clock_divider #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLK_FREQ(12), .DEF_FREQ(2), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_half(wr_half), .clk_div(clk_div), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_rem[i] = 0; m_lvl[i] = 0; m_tick[i] = 0; m_pend[i] = 0;
      m_act[i] = DEF_H; m_pv[i] = DEF_H;
    end
    sb.delete();
  endtask

  // Phase model: m_rem counts down the cycles left in the current half-period.
  task automatic model_step(input logic [1:0] e, input logic w, input logic [1:0] ch,
                            input int h);
    logic [5:0] exp_v;
    for (int i = 0; i < NUM_CH; i++) begin
      int  hh, r;
      bit  hit, ap;
      hh  = (m_act[i] == 0) ? 1 : m_act[i];
      hit = w && (int'(ch) == i);
      if (e[i]) begin
        r  = (m_rem[i] == 0) ? hh : m_rem[i];
        ap = m_lvl[i] && (r == 1);
        r  = r - 1;
        if (r == 0) begin
          m_tick[i] = !m_lvl[i];
          m_lvl[i]  = !m_lvl[i];
        end else m_tick[i] = 0;
        m_rem[i] = r;
      end else begin
        ap = m_pend[i];
        m_rem[i] = 0; m_lvl[i] = 0; m_tick[i] = 0;
      end
      if (hit && ap) begin
        m_act[i] = h; m_pv[i] = h; m_pend[i] = 0;
      end else if (hit) begin
        m_pv[i] = h; m_pend[i] = 1;
      end else if (ap && m_pend[i]) begin
        m_act[i] = m_pv[i]; m_pend[i] = 0;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      exp_v[4+i] = m_lvl[i];
      exp_v[2+i] = m_tick[i];
      exp_v[i]   = m_pend[i];
    end
    sb.push_back(exp_v);
  endtask

  // Called at a negedge; returns after the next negedge.
  task automatic drive(input logic [1:0] e, input logic w, input logic [1:0] ch,
                       input int h, output logic [1:0] tk, output logic [1:0] pd);
    logic [5:0] exp_v, got;
    en = e; wr_en = w; wr_ch = ch; wr_half = CNT_W'(h);
    model_step(e, w, ch, h);
    @(posedge clk); #1;
    cyc++;
    got = {clk_div, tick, pending};
    tk = tick; pd = pending;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty cyc=%0d got=%b", cyc, got);
    end else begin
      exp_v = sb.pop_front();
      if (got !== exp_v) begin
        errors++;
        $display("FAIL cycle_%0d {div,tick,pend} got=%b exp=%b", cyc, got, exp_v);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run(input logic [1:0] e, input int n);
    logic [1:0] tk, pd;
    for (int k = 0; k < n; k++) drive(e, 1'b0, 2'd0, 0, tk, pd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = '0; wr_en = 1'b0; wr_ch = '0; wr_half = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; wr_en = 1'b0; wr_ch = '0; wr_half = '0;
    #12;
    checks++;
    if ({clk_div, tick, pending} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=000000", {clk_div, tick, pending});
    end
    do_reset();
  endtask

  task automatic test_default();
    logic [1:0] tk, pd;
    int t0[$];
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      drive(2'b11, 1'b0, 2'd0, 0, tk, pd);
      if (tk[0]) t0.push_back(k);
    end
    checks++;
    if (t0.size() != 3 || t0[0] != 3 || t0[1] != 9 || t0[2] != 15) begin
      errors++;
      $display("FAIL default_tick_cycles got_n=%0d exp=3,9,15", t0.size());
    end
  endtask

  task automatic test_write_ch0();
    logic [1:0] tk, pd;
    int t0[$];
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      drive(2'b11, k == 4, 2'd0, 5, tk, pd);
      if (tk[0]) t0.push_back(k);
      if (k == 4) begin
        checks++;
        if (pd !== 2'b01) begin
          errors++;
          $display("FAIL write_pending got=%b exp=01", pd);
        end
      end
    end
    checks++;
    if (t0.size() < 2 || t0[1] != 11) begin
      errors++;
      $display("FAIL write_ch0_second_tick got=%0d exp=11", (t0.size() < 2) ? -1 : t0[1]);
    end
  endtask

  task automatic test_bypass();
    logic [1:0] tk, pd;
    do_reset();
    run(2'b11, 5);
    drive(2'b11, 1'b1, 2'd0, 2, tk, pd);
    checks++;
    if (pd[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_pending got=%b exp=0", pd[0]);
    end
    run(2'b11, 12);
  endtask

  task automatic test_zero_half();
    logic [1:0] tk, pd;
    int n = 0;
    do_reset();
    drive(2'b11, 1'b1, 2'd1, 0, tk, pd);
    run(2'b11, 10);
    for (int k = 0; k < 10; k++) begin
      drive(2'b11, 1'b0, 2'd0, 0, tk, pd);
      if (tk[1]) n++;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL zero_half_ticks got=%0d exp=5", n);
    end
  endtask

  task automatic test_disable();
    do_reset();
    run(2'b11, 4);
    run(2'b10, 3);
    run(2'b11, 10);
  endtask

  task automatic test_bad_ch();
    logic [1:0] tk, pd;
    do_reset();
    run(2'b11, 2);
    drive(2'b11, 1'b1, 2'd3, 9, tk, pd);
    checks++;
    if (pd !== 2'b00) begin
      errors++;
      $display("FAIL bad_ch_pending got=%b exp=00", pd);
    end
    run(2'b11, 12);
  endtask

  task automatic test_back_to_back();
    logic [1:0] tk, pd;
    do_reset();
    run(2'b11, 1);
    drive(2'b11, 1'b1, 2'd0, 7, tk, pd);
    drive(2'b11, 1'b1, 2'd0, 2, tk, pd);
    run(2'b11, 16);
    drive(2'b00, 1'b1, 2'd1, 4, tk, pd);
    run(2'b00, 2);
    run(2'b11, 12);
  endtask

  task automatic test_reset_mid();
    logic [1:0] tk, pd;
    do_reset();
    run(2'b11, 4);
    drive(2'b11, 1'b1, 2'd1, 6, tk, pd);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({clk_div, tick, pending} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%b exp=000000", {clk_div, tick, pending});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(2'b11, 14);
  endtask

  initial begin
    test_reset();
    test_default();
    test_write_ch0();
    test_bypass();
    test_zero_half();
    test_disable();
    test_bad_ch();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
